fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage ARM-subset pipeline.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 toward ID.
- Consumes the hazard unit's stall request, the EXE-stage branch redirect and the memory-stage wait signal.
- Keeps two saturating event counters for pipeline debug.

---
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage
//   ARM-subset pipeline.  Holds the fetch PC, drives the instruction-memory
//   address and latches the fetched word plus PC+4 toward decode.  It reacts
//   to three control inputs in a fixed priority:
//     mem_stall > branch_taken > hazard_freeze > normal fetch.
//   Two saturating counters record stall cycles and accepted redirects.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   hazard_freeze  in   hazard-unit stall: hold PC and IF/ID
//   mem_stall      in   memory stage waiting: hold everything except stall count
//   branch_taken   in   redirect request from EXE
//   branch_addr    in   redirect target (byte address, low bits forced to 0)
//   imem_addr      out  instruction-memory address (combinational copy of pc)
//   imem_rdata     in   instruction word read at imem_addr
//   pc             out  current fetch PC
//   id_pc          out  PC+4 of the instruction in IF/ID
//   id_instr       out  instruction in IF/ID
//   id_valid       out  IF/ID holds a real instruction (not a bubble)
//   stall_count    out  saturating count of blocked-PC cycles
//   flush_count    out  saturating count of accepted redirects
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'hE1A00000,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_freeze,
  input  logic              mem_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_instr,
  output logic              id_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_id_pc;
  logic [31:0]       r_id_instr;
  logic              r_id_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_hold;
  logic              w_flush;
  logic              w_freeze;
  logic              w_run;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;

  // Priority decode.  A branch during mem_stall is dropped here because EXE
  // re-presents it once the memory stage releases; a freeze during a branch
  // is dropped because it concerns the instruction being squashed.
  assign w_hold   = mem_stall;
  assign w_flush  = !mem_stall && branch_taken;
  assign w_freeze = !mem_stall && !branch_taken && hazard_freeze;
  assign w_run    = !mem_stall && !branch_taken && !hazard_freeze;

  // Wraps modulo 2^ADDR_W with no overflow indication.
  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  // Targets are word aligned; stray low bits are discarded.
  assign w_target = {branch_addr[ADDR_W-1:2], 2'b00};

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_flush) begin
      r_pc <= w_target;
    end else if (w_run) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID pipeline register; hold and freeze keep id_valid as it was, so a
  // bubble stays a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_pc    <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (w_flush) begin
      r_id_pc    <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (w_run) begin
      r_id_pc    <= w_pc_plus4;
      r_id_instr <= imem_rdata;
      r_id_valid <= 1'b1;
    end
  end

  // Debug counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hold || w_freeze) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_flush) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

  // The only combinational output path is pc -> imem_addr.
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign id_pc       = r_id_pc;
  assign id_instr    = r_id_instr;
  assign id_valid    = r_id_valid;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Randomized bench for fetch_stage with a behavioural model of the stage
//   and a small instruction memory.  Counters are built 4 bits wide so that
//   saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int          ADDR_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'hE1A00000;
  localparam int          CMAX   = 15;

  logic              clk;
  logic              rst;
  logic              hazard_freeze;
  logic              mem_stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] id_pc;
  logic [31:0]       id_instr;
  logic              id_valid;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  fetch_stage #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_freeze(hazard_freeze),
    .mem_stall    (mem_stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 64 words at the bottom, an address-derived pattern
  // everywhere else.
  logic [31:0] mem [64];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a < 32'd256) mem_f = mem[a[7:2]];
    else             mem_f = {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = (imem_addr < 32'd256) ? mem[imem_addr[7:2]]
                                            : {imem_addr[15:0], ~imem_addr[15:0]};

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic        m_id_valid;
  int          m_stall;
  int          m_flush;

  int vectors;
  int miscompares;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_id_pc    = 32'h0;
    m_id_instr = NOP;
    m_id_valid = 1'b0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic check_model();
    chk("imem_addr",   imem_addr,            m_pc);
    chk("pc",          pc,                   m_pc);
    chk("id_pc",       id_pc,                m_id_pc);
    chk("id_instr",    id_instr,             m_id_instr);
    chk("id_valid",    {31'b0, id_valid},    {31'b0, m_id_valid});
    chk("stall_count", {28'b0, stall_count}, 32'(m_stall));
    chk("flush_count", {28'b0, flush_count}, 32'(m_flush));
  endtask

  // One clock: the model's next state comes from the inputs presented before
  // the edge; everything is compared 1 ns after the edge.
  task automatic cycle();
    logic [31:0] n_pc, n_id_pc, n_id_instr;
    logic        n_id_valid;
    int          n_stall, n_flush;
    n_pc = m_pc; n_id_pc = m_id_pc; n_id_instr = m_id_instr;
    n_id_valid = m_id_valid; n_stall = m_stall; n_flush = m_flush;
    if (mem_stall) begin
      n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end else if (branch_taken) begin
      n_pc       = branch_addr & 32'hFFFF_FFFC;
      n_id_instr = NOP;
      n_id_valid = 1'b0;
      n_id_pc    = 32'h0;
      n_flush    = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end else if (hazard_freeze) begin
      n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end else begin
      n_id_instr = mem_f(m_pc);
      n_id_pc    = m_pc + 32'd4;
      n_pc       = m_pc + 32'd4;
      n_id_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_id_pc = n_id_pc; m_id_instr = n_id_instr;
    m_id_valid = n_id_valid; m_stall = n_stall; m_flush = n_flush;
    check_model();
  endtask

  task automatic drive(input logic ms, input logic bt, input logic hf, input logic [31:0] ba);
    mem_stall     = ms;
    branch_taken  = bt;
    hazard_freeze = hf;
    branch_addr   = ba;
  endtask

  task automatic rand_cycle();
    drive(($urandom_range(5) == 0), ($urandom_range(5) == 0),
          ($urandom_range(3) == 0), $urandom);
    if ($urandom_range(3) == 0) branch_addr = 32'($urandom_range(255));
    cycle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'hE3A01001;
    mem[1] = 32'hE3A02002;
    mem[2] = 32'hE0813002;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    model_reset();
    #12;
    chk("rst pc",       pc,                   32'h0);
    chk("rst id_instr", id_instr,             NOP);
    chk("rst id_valid", {31'b0, id_valid},    32'h0);
    chk("rst stall",    {28'b0, stall_count}, 32'h0);
    rst = 1'b0;

    // Two plain fetches
    cycle();
    chk("run1 pc",    pc,       32'h4);
    chk("run1 instr", id_instr, 32'hE3A01001);
    chk("run1 valid", {31'b0, id_valid}, 32'h1);
    cycle();
    chk("run2 pc",    pc,       32'h8);
    chk("run2 id_pc", id_pc,    32'h8);
    chk("run2 instr", id_instr, 32'hE3A02002);

    // Hazard freeze for two cycles at pc=8, then release
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    cycle();
    cycle();
    chk("frz pc",    pc,       32'h8);
    chk("frz instr", id_instr, 32'hE3A02002);
    chk("frz stall", {28'b0, stall_count}, 32'h2);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("rel pc",    pc,       32'hC);
    chk("rel instr", id_instr, 32'hE0813002);

    // Branch with simultaneous freeze: branch wins
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    cycle();
    chk("br pc",    pc,       32'h40);
    chk("br instr", id_instr, NOP);
    chk("br valid", {31'b0, id_valid},    32'h0);
    chk("br flush", {28'b0, flush_count}, 32'h1);
    chk("br stall", {28'b0, stall_count}, 32'h2);

    // Branch held off by mem_stall for three cycles
    drive(1'b1, 1'b1, 1'b0, 32'h80);
    for (int i = 0; i < 3; i++) cycle();
    chk("ms pc",    pc, 32'h40);
    chk("ms stall", {28'b0, stall_count}, 32'h5);
    chk("ms flush", {28'b0, flush_count}, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h80);
    cycle();
    chk("ms br pc",    pc, 32'h80);
    chk("ms br flush", {28'b0, flush_count}, 32'h2);

    // Alignment and wrap
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    cycle();
    chk("aln pc", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("wrap pc",    pc,    32'h0);
    chk("wrap id_pc", id_pc, 32'h0);
    chk("wrap instr", id_instr, 32'hFFFC0003);

    // Randomized traffic
    for (int i = 0; i < 300; i++) rand_cycle();

    // Drive the stall counter into saturation
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat stall", {28'b0, stall_count}, 32'hF);

    // Asynchronous reset between edges while frozen
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst pc",       pc,                   32'h0);
    chk("arst imem",     imem_addr,            32'h0);
    chk("arst id_pc",    id_pc,                32'h0);
    chk("arst id_instr", id_instr,             NOP);
    chk("arst id_valid", {31'b0, id_valid},    32'h0);
    chk("arst stall",    {28'b0, stall_count}, 32'h0);
    chk("arst flush",    {28'b0, flush_count}, 32'h0);
    #1;
    rst = 1'b0;
    cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("post pc",    pc,       32'h4);
    chk("post instr", id_instr, 32'hE3A01001);

    for (int i = 0; i < 300; i++) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
